// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decoder-side
// valid/ready buffer, and branch redirect.
interface instruction_fetch_unit_if #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned SIZE     = 32
);
    logic                mem_req;
    logic [WORDSIZE-1:0] mem_addr;
    logic                mem_ready;
    logic [SIZE-1:0]     mem_rdata;
    logic [SIZE-1:0]     instruction;
    logic [WORDSIZE-1:0] instr_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic                branch_taken;
    logic [WORDSIZE-1:0] branch_target;

    // Fetch unit side
    modport master (
        output mem_req, mem_addr, instruction, instr_pc, instr_valid,
        input  mem_ready, mem_rdata, instr_ready, branch_taken, branch_target
    );

    // Memory / decoder / branch side
    modport slave (
        input  mem_req, mem_addr, instruction, instr_pc, instr_valid,
        output mem_ready, mem_rdata, instr_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one memory request per
// instruction, buffers the returned word with its PC for the decoder, and
// handles branch redirects by squashing any in-flight fetch.
module instruction_fetch_unit #(
    parameter int unsigned         WORDSIZE = 64,
    parameter int unsigned         SIZE     = 32,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                reset,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [WORDSIZE-1:0] pc_q, pc_d;
    logic [SIZE-1:0]     instr_q, instr_d;
    logic [WORDSIZE-1:0] instr_pc_q, instr_pc_d;
    logic                mem_req;
    logic [WORDSIZE-1:0] target_aligned;

    assign target_aligned = {bus.branch_target[WORDSIZE-1:2], 2'b00};

    // Next-state, PC and buffer update; redirect outranks everything but reset
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        mem_req    = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (bus.branch_taken) begin
                    pc_d = target_aligned;
                end else begin
                    mem_req = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.branch_taken) begin
                    pc_d    = target_aligned;
                    // A response landing together with the redirect is the
                    // squashed one, so nothing is left to drain.
                    state_d = bus.mem_ready ? StFetch : StDrain;
                end else if (bus.mem_ready) begin
                    instr_d    = bus.mem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + WORDSIZE'(4);
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (bus.branch_taken) begin
                    pc_d    = target_aligned;
                    state_d = StFetch;
                end else if (bus.instr_ready) begin
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (bus.branch_taken) begin
                    pc_d = target_aligned;
                end
                if (bus.mem_ready) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // State, PC and output buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= {RESET_PC[WORDSIZE-1:2], 2'b00};
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // No request may escape while reset is held, whatever the state
    assign bus.mem_req     = mem_req & ~reset;
    assign bus.mem_addr    = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (state_q == StHold);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed vector table, hand-written redirect/reset
// sequences, a wrap-around instance, and randomized traffic against a
// transaction-level reference model.
module tb_instruction_fetch_unit;

    logic clk;
    logic reset;
    logic rst2;

    instruction_fetch_unit_if #(.WORDSIZE(64), .SIZE(32)) bus ();
    instruction_fetch_unit_if #(.WORDSIZE(64), .SIZE(32)) bus2 ();

    instruction_fetch_unit #(
        .WORDSIZE(64), .SIZE(32), .RESET_PC(64'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    instruction_fetch_unit #(
        .WORDSIZE(64), .SIZE(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
    ) dut_wrap (
        .clk  (clk),
        .reset(rst2),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        rst;
        logic        mrdy;
        logic [31:0] rdata;
        logic        irdy;
        logic        br;
        logic [63:0] tgt;
        logic        ereq;
        logic [63:0] eaddr;
        logic        evalid;
        logic [31:0] einstr;
        logic [63:0] epc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic rst, input logic mrdy, input logic [31:0] rdata,
                                input logic irdy, input logic br, input logic [63:0] tgt,
                                input logic ereq, input logic [63:0] eaddr, input logic evalid,
                                input logic [31:0] einstr, input logic [63:0] epc);
        vec_t v;
        v.rst = rst; v.mrdy = mrdy; v.rdata = rdata; v.irdy = irdy; v.br = br; v.tgt = tgt;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.einstr = einstr; v.epc = epc;
        return v;
    endfunction

    // Apply one cycle of inputs (called just after a falling edge) and check
    task automatic step(input vec_t v, input string nm);
        reset             = v.rst;
        bus.mem_ready     = v.mrdy;
        bus.mem_rdata     = v.rdata;
        bus.instr_ready   = v.irdy;
        bus.branch_taken  = v.br;
        bus.branch_target = v.tgt;
        #1;
        check({nm, ".mem_req"}, {63'd0, bus.mem_req}, {63'd0, v.ereq});
        if (v.ereq) check({nm, ".mem_addr"}, bus.mem_addr, v.eaddr);
        check({nm, ".instr_valid"}, {63'd0, bus.instr_valid}, {63'd0, v.evalid});
        if (v.evalid) begin
            check({nm, ".instruction"}, {32'd0, bus.instruction}, {32'd0, v.einstr});
            check({nm, ".instr_pc"}, bus.instr_pc, v.epc);
        end
        @(negedge clk);
    endtask

    // Reference model: outstanding-request / squash / buffer bookkeeping
    logic [63:0] m_pc;
    logic        m_out;
    logic        m_squash;
    logic        m_buf;
    logic [31:0] m_word;
    logic [63:0] m_bpc;

    task automatic model_step();
        if (reset) begin
            m_pc = 64'h0; m_out = 0; m_squash = 0; m_buf = 0; m_word = 0; m_bpc = 0;
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_target & ~64'h3;
            if (m_buf) m_buf = 0;
            else if (m_out) begin
                if (bus.mem_ready) m_out = 0;
                else m_squash = 1;
            end
        end else if (m_buf) begin
            if (bus.instr_ready) m_buf = 0;
        end else if (m_out) begin
            if (bus.mem_ready) begin
                m_out = 0;
                if (!m_squash) begin
                    m_buf  = 1;
                    m_word = bus.mem_rdata;
                    m_bpc  = m_pc;
                    m_pc   = m_pc + 64'd4;
                end
            end
        end else begin
            m_out    = 1;
            m_squash = 0;
        end
    endtask

    localparam logic [31:0] WA = 32'h00C3_0333;
    localparam logic [31:0] WB = 32'h1234_5678;
    localparam logic [31:0] WC = 32'hDEAD_BEEF;
    localparam logic [31:0] WD = 32'h0000_0013;
    localparam logic [31:0] WE = 32'h00A0_0093;
    localparam logic [31:0] BAD = 32'hBADB_ADBA;

    initial begin
        reset = 1'b1;
        rst2  = 1'b1;
        bus.mem_ready = 0; bus.mem_rdata = 0; bus.instr_ready = 0;
        bus.branch_taken = 0; bus.branch_target = 0;
        bus2.mem_ready = 0; bus2.mem_rdata = 0; bus2.instr_ready = 0;
        bus2.branch_taken = 0; bus2.branch_target = 0;
        @(negedge clk);
        @(negedge clk);

        // Reset state, with reset still held
        #1;
        check("reset.mem_req", {63'd0, bus.mem_req}, 64'd0);
        check("reset.instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        check("reset.instruction", {32'd0, bus.instruction}, 64'd0);
        check("reset.instr_pc", bus.instr_pc, 64'd0);
        @(negedge clk);

        // Basic stream with 1-cycle memory plus 5-cycle backpressure
        tbl.push_back(mk(0, 0, 0,   0, 0, 0, 1, 64'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, WA,  0, 0, 0, 0, 0,     0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, WA, 64'd0));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, 0, 0,     1, WA, 64'd0));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, 1, 64'd4, 0, 0, 0));
        tbl.push_back(mk(0, 1, WB,  1, 0, 0, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, 0, 0,     1, WB, 64'd4));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, 1, 64'd8, 0, 0, 0));
        tbl.push_back(mk(0, 1, WC,  1, 0, 0, 0, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, 0, 0,     1, WC, 64'd8));
        tbl.push_back(mk(0, 0, 0,   1, 0, 0, 1, 64'd12, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl[%0d]", i));

        // Redirect in WAIT, response delayed 3 cycles -> drained
        step(mk(0, 0, 0,   0, 1, 64'h103, 0, 0, 0, 0, 0), "drain0");
        step(mk(0, 0, 0,   0, 0, 0,       0, 0, 0, 0, 0), "drain1");
        step(mk(0, 0, 0,   0, 0, 0,       0, 0, 0, 0, 0), "drain2");
        step(mk(0, 1, BAD, 0, 0, 0,       0, 0, 0, 0, 0), "drain3");
        step(mk(0, 0, 0,   0, 0, 0,       1, 64'h100, 0, 0, 0), "drain_fetch");
        step(mk(0, 1, WD,  0, 0, 0,       0, 0, 0, 0, 0), "drain_wait");
        // Redirect in HOLD with instr_ready: no transfer
        step(mk(0, 0, 0,   1, 1, 64'h200, 0, 0, 1, WD, 64'h100), "hold_br");
        step(mk(0, 0, 0,   0, 0, 0,       1, 64'h200, 0, 0, 0), "hold_br_fetch");
        // Redirect with mem_ready same cycle in WAIT: straight to FETCH
        step(mk(0, 1, BAD, 0, 1, 64'h300, 0, 0, 0, 0, 0), "wait_br_rdy");
        // Redirect in FETCH suppresses the request
        step(mk(0, 0, 0,   0, 1, 64'h404, 0, 0, 0, 0, 0), "fetch_br");
        step(mk(0, 0, 0,   0, 0, 0,       1, 64'h404, 0, 0, 0), "fetch_br_after");
        // Reset in WAIT, then a stale response in FETCH
        step(mk(1, 0, 0,   0, 0, 0,       0, 0, 0, 0, 0), "rst_wait");
        step(mk(0, 1, BAD, 0, 0, 0,       1, 64'd0, 0, 0, 0), "stale_rdy");
        step(mk(0, 0, 0,   0, 0, 0,       0, 0, 0, 0, 0), "stale_wait");
        step(mk(0, 1, WE,  0, 0, 0,       0, 0, 0, 0, 0), "fresh_rsp");
        step(mk(0, 0, 0,   1, 0, 0,       0, 0, 1, WE, 64'd0), "fresh_hold");
        step(mk(0, 0, 0,   0, 0, 0,       1, 64'd4, 0, 0, 0), "fresh_fetch");

        // PC wrap on the second instance
        rst2 = 1'b0;
        #1;
        check("wrap.mem_req", {63'd0, bus2.mem_req}, 64'd1);
        check("wrap.mem_addr", bus2.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        bus2.mem_ready = 1; bus2.mem_rdata = WA;
        @(negedge clk);
        bus2.mem_ready = 0; bus2.instr_ready = 1;
        #1;
        check("wrap.instr_valid", {63'd0, bus2.instr_valid}, 64'd1);
        check("wrap.instr_pc", bus2.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap.instruction", {32'd0, bus2.instruction}, {32'd0, WA});
        @(negedge clk);
        #1;
        check("wrap.next_req", {63'd0, bus2.mem_req}, 64'd1);
        check("wrap.next_addr", bus2.mem_addr, 64'd0);

        // Randomized traffic against the reference model
        @(negedge clk);
        reset = 1; bus.branch_taken = 0; bus.mem_ready = 0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            check("rnd.instr_valid", {63'd0, bus.instr_valid}, {63'd0, m_buf});
            check("rnd.instruction", {32'd0, bus.instruction}, {32'd0, m_word});
            check("rnd.instr_pc", bus.instr_pc, m_bpc);
            reset             = ($urandom_range(63) == 0);
            bus.branch_taken  = ($urandom_range(9) == 0);
            bus.branch_target = {$urandom, $urandom};
            bus.mem_ready     = ($urandom_range(2) == 0);
            bus.mem_rdata     = $urandom;
            bus.instr_ready   = $urandom_range(1) == 1;
            #1;
            check("rnd.mem_req", {63'd0, bus.mem_req},
                  {63'd0, !reset && !m_out && !m_buf && !bus.branch_taken});
            if (!reset && !m_out && !m_buf && !bus.branch_taken)
                check("rnd.mem_addr", bus.mem_addr, m_pc);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
